// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Instruction fetch stage of the Beta pipeline. Owns the PC, issues
//            at most one outstanding request to instruction memory and drives
//            the IF/ID pipeline register consumed by decode. A one-entry hold
//            buffer absorbs a response that arrives while decode is stalled.
//            Branch/jump redirects from decode squash wrong-path fetches.
// Ports    : clk, rst_n               clock, async active-low reset
//            imem_req_valid/ready/addr request channel (addr word aligned)
//            imem_resp_valid/data      in-order response channel
//            stall                     decode cannot accept; hold valid IF/ID
//            redirect/redirect_addr    taken branch/jump from decode
//            inst/pc_plus_four/inst_valid  registered IF/ID outputs
// Revision : 1.0  initial release
// ============================================================================
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] NOP_INST     = 32'h83FF_F800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] inst,
    output logic [31:0] pc_plus_four,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic [31:0] r_tag_pc4, w_tag_nxt;
    logic [31:0] r_hold_inst, w_hold_inst_nxt;
    logic [31:0] r_hold_pc4, w_hold_pc4_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_inst_valid, w_inst_valid_nxt;

    logic        w_req_hs;
    logic        w_ifid_free;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;
    logic        w_new_valid;
    logic [31:0] w_new_inst;
    logic [31:0] w_new_pc4;
    logic        w_unused_addr_lsbs;

    // Request channel decodes straight from state and PC.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = {r_pc[31:2], 2'b00};

    assign w_req_hs    = imem_req_valid && imem_req_ready;
    // Stall only protects a valid instruction; a bubble may be overwritten.
    assign w_ifid_free = !stall || !r_inst_valid;
    // Increment never touches the supervisor bit; bits 30:0 wrap.
    assign w_pc_inc    = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_redir_pc  = {redirect_addr[31:2], 2'b00};
    assign w_unused_addr_lsbs = ^redirect_addr[1:0];

    assign inst         = r_inst;
    assign pc_plus_four = r_pc4;
    assign inst_valid   = r_inst_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_VECTOR;
            r_kill       <= 1'b0;
            r_tag_pc4    <= RESET_VECTOR;
            r_hold_inst  <= NOP_INST;
            r_hold_pc4   <= RESET_VECTOR;
            r_inst       <= NOP_INST;
            r_pc4        <= RESET_VECTOR;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_tag_pc4    <= w_tag_nxt;
            r_hold_inst  <= w_hold_inst_nxt;
            r_hold_pc4   <= w_hold_pc4_nxt;
            r_inst       <= w_inst_nxt;
            r_pc4        <= w_pc4_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_kill_nxt      = r_kill;
        w_tag_nxt       = r_tag_pc4;
        w_hold_inst_nxt = r_hold_inst;
        w_hold_pc4_nxt  = r_hold_pc4;
        w_new_valid     = 1'b0;
        w_new_inst      = r_hold_inst;
        w_new_pc4       = r_hold_pc4;

        case (r_state)
            S_REQ: begin
                if (w_req_hs) begin
                    w_tag_nxt   = w_pc_inc;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_WAIT;
                end
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                    // The request just accepted is on the wrong path.
                    if (w_req_hs) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (r_kill || redirect) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                        if (redirect) begin
                            w_pc_nxt = w_redir_pc;
                        end
                    end else if (w_ifid_free) begin
                        w_new_valid = 1'b1;
                        w_new_inst  = imem_resp_data;
                        w_new_pc4   = r_tag_pc4;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_hold_inst_nxt = imem_resp_data;
                        w_hold_pc4_nxt  = r_tag_pc4;
                        w_state_nxt     = S_FULL;
                    end
                end else if (redirect) begin
                    // Response still in flight: mark it for discard.
                    w_kill_nxt = 1'b1;
                    w_pc_nxt   = w_redir_pc;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (w_ifid_free) begin
                    w_new_valid = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        // IF/ID: redirect > stall-hold of valid inst > load > bubble.
        w_inst_nxt       = r_inst;
        w_pc4_nxt        = r_pc4;
        w_inst_valid_nxt = r_inst_valid;
        if (redirect) begin
            w_inst_nxt       = NOP_INST;
            w_inst_valid_nxt = 1'b0;
        end else if (stall && r_inst_valid) begin
            w_inst_nxt       = r_inst;
        end else if (w_new_valid) begin
            w_inst_nxt       = w_new_inst;
            w_pc4_nxt        = w_new_pc4;
            w_inst_valid_nxt = 1'b1;
        end else begin
            w_inst_nxt       = NOP_INST;
            w_inst_valid_nxt = 1'b0;
        end
    end

endmodule
`default_nettype wire
